// File: rtl/analog_io_ctrl_if.sv
// Request/response handshake bundle between a requester and the analog I/O sequencer.
interface analog_io_ctrl_if #(
    parameter int unsigned BITS = 16
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [BITS-1:0] req_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BITS-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/analog_io_ctrl.sv
// Sequences single read/write requests onto a bidirectional analog port, inserting a
// turnaround settle on direction changes and averaging 2^AVG_LOG2 samples per read.
module analog_io_ctrl #(
    parameter int unsigned BITS          = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic            clk,
    input  logic            rst,
    analog_io_ctrl_if.slave bus,
    output logic            busy_o,
    output logic            io_en_o,
    output logic            io_direction_o,
    output logic [BITS-1:0] io_data_in_o,
    input  logic [BITS-1:0] io_data_out_i
);
    typedef enum logic [2:0] {IDLE, SETTLE, WRITE, SAMPLE, RESP} state_e;

    localparam int unsigned NUM_SAMPLES = 1 << AVG_LOG2;
    localparam int unsigned CNT_MAX     = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
    localparam int unsigned ACC_W       = BITS + AVG_LOG2;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(NUM_SAMPLES - 1);

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic              write_q, write_d;
    logic [BITS-1:0]   data_in_q, data_in_d;
    logic [BITS-1:0]   rsp_data_q, rsp_data_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_sum;

    assign acc_sum = acc_q + ACC_W'(io_data_out_i);

    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        write_d    = write_q;
        data_in_d  = data_in_q;
        rsp_data_d = rsp_data_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    dir_d   = bus.req_write;
                    cnt_d   = '0;
                    if (bus.req_write) data_in_d = bus.req_data;
                    if ((bus.req_write != dir_q) && (SETTLE_CYCLES != 0)) state_d = SETTLE;
                    else state_d = bus.req_write ? WRITE : SAMPLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = write_q ? WRITE : SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE: begin
                rsp_data_d = data_in_q;
                state_d    = RESP;
            end
            SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    // Accumulator is wide enough that the full sum never wraps before the shift.
                    rsp_data_d = BITS'(acc_sum >> AVG_LOG2);
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = RESP;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            write_q    <= 1'b0;
            data_in_q  <= '0;
            rsp_data_q <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            write_q    <= write_d;
            data_in_q  <= data_in_d;
            rsp_data_q <= rsp_data_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_data   = rsp_data_q;
    assign busy_o         = (state_q != IDLE);
    assign io_en_o        = (state_q == SETTLE) || (state_q == WRITE) || (state_q == SAMPLE);
    assign io_direction_o = dir_q;
    assign io_data_in_o   = data_in_q;
endmodule
